// File: rtl/bus_timer_pkg.sv
// Shared definitions for the bus_timer responder:
// register offsets, CTRL/STATUS bit positions and reset values.
package bus_timer_pkg;

  typedef enum logic [2:0] {
    TimerRegCtrl     = 3'd0,
    TimerRegStatus   = 3'd1,
    TimerRegReloadLo = 3'd2,
    TimerRegReloadHi = 3'd3,
    TimerRegCountLo  = 3'd4,
    TimerRegCountHi  = 3'd5,
    TimerRegPrescale = 3'd6,
    TimerRegReserved = 3'd7
  } timer_reg_e;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlReloadBit = 1;
  localparam int unsigned CtrlIeBit     = 2;
  localparam int unsigned StatusExpBit  = 0;
  localparam int unsigned StatusRunBit  = 1;

  localparam logic [7:0]  RegRst   = 8'h00;
  localparam logic [15:0] CountRst = 16'h0000;

endpackage

// File: rtl/timer_prescaler.sv
// Prescaler: 8-bit up-counter, wraps at cmp and emits a tick.
// Ports: clk_in, reset (async low), en, clr, cmp[7:0] -> tick.
module timer_prescaler
  import bus_timer_pkg::*;
(
  input  logic       clk_in,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  input  logic [7:0] cmp,
  output logic       tick
);

  logic [7:0] presc;
  logic       hit;

  assign hit = (presc == cmp);

  // A clear on this edge wins over a tick on the same edge.
  assign tick = en & hit & ~clr;

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      presc <= RegRst;
    end else if (clr) begin
      presc <= RegRst;
    end else if (en) begin
      presc <= hit ? RegRst : presc + 8'd1;
    end
  end

endmodule

// File: rtl/bus_timer.sv
// Memory-mapped interval timer responder for cpu6502.
// Ports: clk_in, reset (async low), address, read_write,
//        data_in -> data_out, selected, nmib (active low).
module bus_timer
  import bus_timer_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h6000
) (
  input  logic        clk_in,
  input  logic        reset,
  input  logic [15:0] address,
  input  logic        read_write,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        selected,
  output logic        nmib
);

  timer_reg_e  off;
  logic        wr;
  logic        rd;
  logic        load;
  logic        tick;
  logic        zero;
  logic        expire;
  logic        clr_exp;

  logic        en;
  logic        rld;
  logic        ie;
  logic        exp_q;
  logic [7:0]  reload_lo;
  logic [7:0]  reload_hi;
  logic [7:0]  prescale;
  logic [7:0]  snap;
  logic [15:0] count;

  assign selected = (address[15:3] == BASE_ADDR[15:3]);
  assign off      = timer_reg_e'(address[2:0]);
  assign wr       = selected & read_write;
  assign rd       = selected & ~read_write;

  // RELOAD_HI write reloads the count and restarts the prescaler.
  assign load    = wr & (off == TimerRegReloadHi);
  assign zero    = (count == CountRst);
  assign expire  = tick & zero;
  assign clr_exp = wr & (off == TimerRegStatus)
                 & data_in[StatusExpBit];

  assign nmib = ~(exp_q & ie);

  timer_prescaler u_presc (
    .clk_in (clk_in),
    .reset  (reset),
    .en     (en),
    .clr    (load),
    .cmp    (prescale),
    .tick   (tick)
  );

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      en        <= 1'b0;
      rld       <= 1'b0;
      ie        <= 1'b0;
      reload_lo <= RegRst;
      reload_hi <= RegRst;
      prescale  <= RegRst;
    end else begin
      if (expire && !rld) begin
        en <= 1'b0;
      end
      if (wr) begin
        unique case (off)
          TimerRegCtrl: begin
            en  <= data_in[CtrlEnBit];
            rld <= data_in[CtrlReloadBit];
            ie  <= data_in[CtrlIeBit];
          end
          TimerRegReloadLo: reload_lo <= data_in;
          TimerRegReloadHi: reload_hi <= data_in;
          TimerRegPrescale: prescale  <= data_in;
          default: ;
        endcase
      end
    end
  end

  // Set has priority over write-1-to-clear.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      exp_q <= 1'b0;
    end else if (expire) begin
      exp_q <= 1'b1;
    end else if (clr_exp) begin
      exp_q <= 1'b0;
    end
  end

  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      count <= CountRst;
    end else if (load) begin
      count <= {data_in, reload_lo};
    end else if (tick) begin
      if (!zero) begin
        count <= count - 16'd1;
      end else if (rld) begin
        count <= {reload_hi, reload_lo};
      end else begin
        count <= CountRst;
      end
    end
  end

  // High byte captured on a low-byte read for coherent 16-bit reads.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      snap <= RegRst;
    end else if (rd && off == TimerRegCountLo) begin
      snap <= count[15:8];
    end
  end

  always_comb begin
    data_out = RegRst;
    if (rd) begin
      unique case (off)
        TimerRegCtrl:     data_out = {5'd0, ie, rld, en};
        TimerRegStatus:   data_out = {6'd0, en, exp_q};
        TimerRegReloadLo: data_out = reload_lo;
        TimerRegReloadHi: data_out = reload_hi;
        TimerRegCountLo:  data_out = count[7:0];
        TimerRegCountHi:  data_out = snap;
        TimerRegPrescale: data_out = prescale;
        TimerRegReserved: data_out = RegRst;
      endcase
    end
  end

endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: directed scenarios plus
// randomized bus traffic against a behavioural model.
module tb_bus_timer;

  logic        clk_in;
  logic        reset;
  logic [15:0] address;
  logic        read_write;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic        selected;
  logic        nmib;

  int checks = 0;
  int errors = 0;

  logic m_en, m_rl, m_ie, m_exp;
  logic [7:0]  m_rlo, m_rhi, m_ps, m_presc, m_snap;
  logic [15:0] m_count;
  logic        sel_q;

  bus_timer #(.BASE_ADDR(16'h6000)) dut (
    .clk_in     (clk_in),
    .reset      (reset),
    .address    (address),
    .read_write (read_write),
    .data_in    (data_in),
    .data_out   (data_out),
    .selected   (selected),
    .nmib       (nmib)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout need=finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [15:0] got,
                     input logic [15:0] need);
    checks++;
    if (got !== need) begin
      errors++;
      $display("FAIL %s got=%h need=%h", tag, got, need);
    end
  endtask

  task automatic m_reset();
    {m_en, m_rl, m_ie, m_exp} = '0;
    {m_rlo, m_rhi, m_ps, m_presc, m_snap} = '0;
    m_count = '0;
  endtask

  function automatic logic m_sel(input logic [15:0] a);
    return (a >= 16'h6000) && (a <= 16'h6007);
  endfunction

  function automatic logic [7:0] m_read(input logic [15:0] a,
                                        input logic rw);
    if (!m_sel(a) || rw) return 8'h00;
    case (a[2:0])
      3'd0: return {5'd0, m_ie, m_rl, m_en};
      3'd1: return {6'd0, m_en, m_exp};
      3'd2: return m_rlo;
      3'd3: return m_rhi;
      3'd4: return m_count[7:0];
      3'd5: return m_snap;
      3'd6: return m_ps;
      default: return 8'h00;
    endcase
  endfunction

  // One clock edge of the timer, from the register-map rules.
  task automatic m_step(input logic [15:0] a, input logic rw,
                        input logic [7:0] d);
    logic wr, rd, ld, tick, fire;
    logic [2:0] off;
    wr   = m_sel(a) && rw;
    rd   = m_sel(a) && !rw;
    off  = a[2:0];
    ld   = wr && off == 3'd3;
    tick = m_en && (m_presc == m_ps) && !ld;
    fire = tick && m_count == 16'd0;
    if (rd && off == 3'd4) m_snap = m_count[15:8];
    if (ld) begin
      m_count = {d, m_rlo};
      m_presc = 8'd0;
    end else begin
      if (m_en) m_presc = (m_presc == m_ps) ? 8'd0 : m_presc + 8'd1;
      if (tick) begin
        if (!fire) m_count = m_count - 16'd1;
        else m_count = m_rl ? {m_rhi, m_rlo} : 16'd0;
      end
    end
    if (fire && !m_rl) m_en = 1'b0;
    if (wr) begin
      case (off)
        3'd0: {m_ie, m_rl, m_en} = d[2:0];
        3'd1: if (d[0]) m_exp = 1'b0;
        3'd2: m_rlo = d;
        3'd3: m_rhi = d;
        3'd6: m_ps = d;
        default: ;
      endcase
    end
    if (fire) m_exp = 1'b1;
  endtask

  task automatic cyc(input logic [15:0] a, input logic rw,
                     input logic [7:0] d, output logic [7:0] q);
    address    = a;
    read_write = rw;
    data_in    = d;
    #1;
    q     = data_out;
    sel_q = selected;
    chk("sel", {15'd0, selected}, {15'd0, m_sel(a)});
    chk("rdata", {8'd0, data_out}, {8'd0, m_read(a, rw)});
    chk("nmib", {15'd0, nmib}, {15'd0, !(m_exp && m_ie)});
    @(posedge clk_in);
    m_step(a, rw, d);
    #1;
  endtask

  task automatic wr(input logic [2:0] off, input logic [7:0] d);
    logic [7:0] q;
    cyc(16'h6000 + {13'd0, off}, 1'b1, d, q);
  endtask

  task automatic rd(input logic [2:0] off, output logic [7:0] q);
    cyc(16'h6000 + {13'd0, off}, 1'b0, 8'h00, q);
  endtask

  task automatic idle(input int n);
    logic [7:0] q;
    for (int i = 0; i < n; i++) cyc(16'h0000, 1'b0, 8'h00, q);
  endtask

  task automatic wait_low(output int n);
    n = 0;
    while (nmib !== 1'b0 && n < 64) begin
      idle(1);
      n++;
    end
  endtask

  initial begin
    logic [7:0] q;
    int n;
    reset      = 1'b0;
    address    = 16'h0000;
    read_write = 1'b0;
    data_in    = 8'h00;
    m_reset();
    #12 reset = 1'b1;
    @(posedge clk_in);
    #1;

    // 1: reset in the middle of a running count
    wr(3'd6, 8'h00);
    wr(3'd2, 8'h50);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h07);
    idle(10);
    #2 reset = 1'b0;
    m_reset();
    #1;
    chk("rst_nmib", {15'd0, nmib}, 16'd1);
    chk("rst_dout", {8'd0, data_out}, 16'd0);
    @(posedge clk_in);
    #1 reset = 1'b1;
    for (int i = 0; i < 8; i++) begin
      rd(i[2:0], q);
      chk("rst_reg", {8'd0, q}, 16'd0);
    end

    // 2: one-shot, reload 3, prescale 0
    wr(3'd6, 8'h00);
    wr(3'd2, 8'h03);
    wr(3'd3, 8'h00);
    wr(3'd0, 8'h05);
    wait_low(n);
    chk("os_lat", n[15:0], 16'd4);
    rd(3'd1, q);
    chk("os_stat", {8'd0, q}, 16'h0001);
    rd(3'd0, q);
    chk("os_ctrl", {8'd0, q}, 16'h0004);
    rd(3'd4, q);
    chk("os_cnt", {8'd0, q}, 16'd0);

    // 3: auto reload 2, prescale 1 -> 6-cycle period
    wr(3'd6, 8'h01);
    wr(3'd2, 8'h02);
    wr(3'd3, 8'h00);
    wr(3'd1, 8'h01);
    wr(3'd0, 8'h07);
    wait_low(n);
    chk("ar_first", n[15:0], 16'd6);
    wr(3'd1, 8'h01);
    chk("ar_clr", {15'd0, nmib}, 16'd1);
    wait_low(n);
    chk("ar_again", n[15:0], 16'd5);

    // 4: coherent 16-bit count read
    wr(3'd0, 8'h00);
    wr(3'd1, 8'h01);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h01);
    wr(3'd6, 8'h00);
    rd(3'd4, q);
    chk("snap_lo", {8'd0, q}, 16'h0000);
    wr(3'd0, 8'h01);
    idle(2);
    rd(3'd5, q);
    chk("snap_hi", {8'd0, q}, 16'h0001);

    // 5a: status clear on the expiry edge
    wr(3'd0, 8'h00);
    wr(3'd2, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd1, 8'h01);
    wr(3'd0, 8'h05);
    wr(3'd1, 8'h01);
    chk("race_nmib", {15'd0, nmib}, 16'd0);
    rd(3'd1, q);
    chk("race_stat", {8'd0, q}, 16'h0001);

    // 5b: RELOAD_HI write on a tick edge with count 0
    wr(3'd1, 8'h01);
    wr(3'd0, 8'h00);
    wr(3'd3, 8'h00);
    wr(3'd2, 8'h34);
    wr(3'd0, 8'h03);
    wr(3'd3, 8'h12);
    rd(3'd4, q);
    chk("ld_lo", {8'd0, q}, 16'h0034);
    rd(3'd1, q);
    chk("ld_stat", {8'd0, q}, 16'h0002);
    wr(3'd0, 8'h00);

    // 6: outside the window and the reserved offset
    cyc(16'h6008, 1'b1, 8'hFF, q);
    chk("out_sel", {15'd0, sel_q}, 16'd0);
    cyc(16'h5FFF, 1'b1, 8'hFF, q);
    cyc(16'h6008, 1'b0, 8'h00, q);
    chk("out_rd", {8'd0, q}, 16'd0);
    cyc(16'h5FFF, 1'b0, 8'h00, q);
    chk("out_rd2", {8'd0, q}, 16'd0);
    rd(3'd6, q);
    chk("out_ps", {8'd0, q}, 16'd0);
    wr(3'd7, 8'hA5);
    rd(3'd7, q);
    chk("resv", {8'd0, q}, 16'd0);

    // Random bus traffic
    for (int i = 0; i < 800; i++) begin
      logic [15:0] a;
      logic [7:0]  d;
      int r;
      r = $urandom_range(0, 9);
      if (r < 8) a = 16'h6000 + r[15:0];
      else if (r == 8) a = 16'h6008;
      else a = 16'h5FFF;
      d = 8'($urandom);
      if (a == 16'h6006) d = d & 8'h03;
      if (a == 16'h6003) d = d & 8'h01;
      cyc(a, 1'($urandom), d, q);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
